imem_loadable: RTL and testbench
================================

# imem_loadable

Parametrised instruction memory for the single-cycle and pipelined MIPS cores, replacing the fixed 64-word ROM. It clears itself after reset, accepts a program over a streaming load port, and serves fetches through a valid/ready port with one-cycle registered read latency. It also flags misaligned and out-of-range PCs. It sits between the PC/IF stage and the testbench or boot loader that supplies program images.

## Interface
- DATA_W, 32, instruction word width in bits
- DEPTH, 64, number of words; power of two, at least 4
- PC_W, 32, fetch PC width in bits (byte address)
- FILL_WORD, 32'h0000_0000, value written by clear and returned on fault (MIPS NOP)

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- load_start  in  1  request to begin a program load at word 0
- load_valid  in  1  load_data is valid
- load_data  in  DATA_W  next program word
- load_last  in  1  marks the final word of the image
- load_ready  out  1  the block accepts a load word this cycle
- load_done  out  1  one-cycle pulse when a load terminates
- fetch_valid  in  1  fetch request
- fetch_pc  in  PC_W  byte address of the requested instruction
- fetch_ready  out  1  the block accepts a fetch this cycle
- instr_valid  out  1  instruction is valid this cycle
- instruction  out  DATA_W  fetched word
- fault_misalign  out  1  qualifies instr_valid: fetch_pc[1:0] was not zero
- fault_range  out  1  qualifies instr_valid: fetch_pc>>2 was at least DEPTH

## Operation
- The FSM has three states: CLEAR, RUN and LOAD.
- Reset state is CLEAR with ptr=0.
- CLEAR:
  - Writes FILL_WORD to word ptr each cycle and increments ptr.
  - After writing word DEPTH-1, goes to RUN with ptr=0.
  - load_ready=0 and fetch_ready=0.
- RUN:
  - fetch_ready=1 and load_ready=0.
  - When load_start=1, goes to LOAD next cycle with ptr=0.
- LOAD:
  - load_ready=1 and fetch_ready=0.
  - Each cycle with load_valid&load_ready, writes load_data to word ptr and increments ptr.
  - The load ends on the accepted word that has load_last=1, or on the accepted write to word DEPTH-1, whichever comes first.
  - At the end: load_done pulses, the FSM returns to RUN, and ptr is cleared.
  - Words not written keep their previous contents.
  - load_start is ignored while in LOAD or CLEAR.
- Fetch:
  - A fetch is accepted when fetch_valid&fetch_ready.
  - Word index is fetch_pc>>2, truncated to log2(DEPTH) bits only after the range check.
  - Misaligned or out-of-range fetch: instruction=FILL_WORD, the matching fault bit is 1, and instr_valid=1. Both fault bits may be 1 together.
- instruction holds its last value when no fetch is accepted. instr_valid and the fault bits are 0 in that case.
- Memory is write-first relative to fetch only by construction: fetch and write are never active in the same cycle.

## Timing
- Reset values: load_ready=0, load_done=0, fetch_ready=0, instr_valid=0, instruction=0, both fault bits=0.
- Memory contents are undefined until CLEAR completes.
- Clear takes DEPTH cycles after rst deasserts. fetch_ready first rises in cycle DEPTH (counting from 0 at the first edge after release).
- Fetch latency is 1: accepted at edge N gives instruction, instr_valid and faults during cycle N+1 (valid after edge N+1). Fetches can be accepted back-to-back, one per cycle.
- Simultaneous load_start and accepted fetch in RUN:
  - The fetch completes normally next cycle.
  - LOAD is entered at the same edge.
  - fetch_ready=0 from that cycle.
- load_done asserts in the cycle after the terminating write edge, for exactly one cycle. fetch_ready=1 in that same cycle.
- rst asserted mid-load or mid-clear:
  - All outputs go to reset values immediately.
  - A full CLEAR restarts, and loaded contents are lost.
- load_valid while load_ready=0 is dropped; the source must hold it.

## Structure
- Package imem_pkg:
  - State enum {CLEAR, RUN, LOAD}.
  - NOP constant 32'h0.
  - Function clog2 for index width.
- Sub-module imem_array:
  - DEPTH×DATA_W storage.
  - One synchronous write port (we, waddr, wdata).
  - One registered read port (re, raddr, rdata); rdata holds when re=0.
- Top-level contents: FSM, ptr counter, range/alignment check, fault registers.

## Test plan
- Reset release with DEPTH=64: fetch_ready=0 for 64 cycles. Then fetch pc=0x0 returns 0x00000000 with no faults.
- Load 3 words (0x20090006, 0x20080001, 0x01084020; last on the third):
  - load_done pulses one cycle after the third word is accepted.
  - Fetches of pc 0x0, 0x4 and 0x8 return those words, one cycle after each request.
- Misaligned and out-of-range fetches:
  - Fetch pc=0x6: fault_misalign=1, instruction=0.
  - Fetch pc=0x100 with DEPTH=64: fault_range=1, instruction=0.
  - Fetch pc=0x102: both fault bits = 1.
- Overflow load with DEPTH=4: stream 6 words with no load_last.
  - Only 4 words are accepted; load_ready drops after the fourth; load_done pulses.
  - Words 0–3 read back as the first 4 values.
- Partial reload: after a 4-word load, load 1 word 0xDEADBEEF with last=1.
  - Word 0 = 0xDEADBEEF.
  - Words 1–3 are unchanged.
- Reset mid-load: assert rst after 2 of 5 words.
  - Outputs return to 0.
  - After the 64-cycle clear, all words read 0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
package imem_pkg;

  // Controller states: self-clear after reset, normal fetch service, program load.
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2
  } imem_state_e;

  // MIPS NOP (sll $0,$0,0); used as the clear/fault fill value.
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Ceiling log2, used to size the word index from DEPTH.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_W storage with one synchronous write port and one registered read port.
module imem_array
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Synchronous write of one word.
  // NOTE: the storage array is deliberately not reset; resetting it would turn
  // the RAM into DEPTH*DATA_W flops. The CLEAR pass initialises it instead.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Registered read; output register holds its value while re is low.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     r_rdata <= '0;
    else if (re) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: self-clearing after reset, streaming program load,
// one-cycle registered fetch with misalignment and range fault flags.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int              DATA_W    = 32,
  parameter int              DEPTH     = 64,
  parameter int              PC_W      = 32,
  parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  input  logic              fetch_valid,
  input  logic [PC_W-1:0]   fetch_pc,
  output logic              fetch_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instruction,
  output logic              fault_misalign,
  output logic              fault_range
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  imem_state_e       r_state, w_state_nxt;
  logic [AW-1:0]     r_ptr, w_ptr_nxt;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_load_end;

  logic              w_fetch_acc;
  logic [PC_W-1:0]   w_word;
  logic              w_misalign;
  logic              w_range;
  logic [DATA_W-1:0] w_rdata;

  logic              r_load_done;
  logic              r_instr_valid;
  logic              r_fault_misalign;
  logic              r_fault_range;
  logic              r_last_fault;

  // State and write-pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next-state, pointer update, write-port control and handshake readies.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_we        = 1'b0;
    w_waddr     = r_ptr;
    w_wdata     = FILL_WORD;
    w_load_end  = 1'b0;
    load_ready  = 1'b0;
    fetch_ready = 1'b0;
    unique case (r_state)
      CLEAR: begin
        w_we = 1'b1;
        if (r_ptr == LAST_IDX) begin
          w_state_nxt = RUN;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + 1'b1;
        end
      end
      RUN: begin
        fetch_ready = 1'b1;
        if (load_start) begin
          w_state_nxt = LOAD;
          w_ptr_nxt   = '0;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          w_we    = 1'b1;
          w_wdata = load_data;
          if (load_last || (r_ptr == LAST_IDX)) begin
            w_load_end  = 1'b1;
            w_state_nxt = RUN;
            w_ptr_nxt   = '0;
          end else begin
            w_ptr_nxt = r_ptr + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = CLEAR;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // Fetch decode: range check uses the full word index before truncation.
  assign w_fetch_acc = fetch_valid & fetch_ready;
  assign w_word      = fetch_pc >> 2;
  assign w_misalign  = |fetch_pc[1:0];
  assign w_range     = (w_word >= PC_W'(DEPTH));

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (w_wdata),
    .re    (w_fetch_acc),
    .raddr (w_word[AW-1:0]),
    .rdata (w_rdata)
  );

  // Fetch response flags, load-done pulse and the sticky "last fetch faulted" bit
  // that keeps instruction at FILL_WORD until the next accepted fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load_done      <= 1'b0;
      r_instr_valid    <= 1'b0;
      r_fault_misalign <= 1'b0;
      r_fault_range    <= 1'b0;
      r_last_fault     <= 1'b0;
    end else begin
      r_load_done      <= w_load_end;
      r_instr_valid    <= w_fetch_acc;
      r_fault_misalign <= w_fetch_acc & w_misalign;
      r_fault_range    <= w_fetch_acc & w_range;
      if (w_fetch_acc) r_last_fault <= w_misalign | w_range;
    end
  end

  assign load_done      = r_load_done;
  assign instr_valid    = r_instr_valid;
  assign fault_misalign = r_fault_misalign;
  assign fault_range    = r_fault_range;
  assign instruction    = r_last_fault ? FILL_WORD : w_rdata;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench: instance 0 has DEPTH=64, instance 1 has DEPTH=4.
module tb_imem_loadable;

  logic        clk;
  logic        rst;
  logic        load_start  [2];
  logic        load_valid  [2];
  logic [31:0] load_data   [2];
  logic        load_last   [2];
  logic        load_ready  [2];
  logic        load_done   [2];
  logic        fetch_valid [2];
  logic [31:0] fetch_pc    [2];
  logic        fetch_ready [2];
  logic        instr_valid [2];
  logic [31:0] instruction [2];
  logic        fault_misalign [2];
  logic        fault_range    [2];

  int n_tests = 0;
  int n_fail  = 0;

  imem_loadable #(.DATA_W(32), .DEPTH(64), .PC_W(32), .FILL_WORD(32'h0)) u_dut64 (
    .clk(clk), .rst(rst),
    .load_start(load_start[0]), .load_valid(load_valid[0]), .load_data(load_data[0]),
    .load_last(load_last[0]), .load_ready(load_ready[0]), .load_done(load_done[0]),
    .fetch_valid(fetch_valid[0]), .fetch_pc(fetch_pc[0]), .fetch_ready(fetch_ready[0]),
    .instr_valid(instr_valid[0]), .instruction(instruction[0]),
    .fault_misalign(fault_misalign[0]), .fault_range(fault_range[0])
  );

  imem_loadable #(.DATA_W(32), .DEPTH(4), .PC_W(32), .FILL_WORD(32'h0)) u_dut4 (
    .clk(clk), .rst(rst),
    .load_start(load_start[1]), .load_valid(load_valid[1]), .load_data(load_data[1]),
    .load_last(load_last[1]), .load_ready(load_ready[1]), .load_done(load_done[1]),
    .fetch_valid(fetch_valid[1]), .fetch_pc(fetch_pc[1]), .fetch_ready(fetch_ready[1]),
    .instr_valid(instr_valid[1]), .instruction(instruction[1]),
    .fault_misalign(fault_misalign[1]), .fault_range(fault_range[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One accepted fetch, then check the response visible after the next edge.
  task automatic fetch_chk(input int d, input logic [31:0] pc, input logic [31:0] exp_instr,
                           input logic exp_mis, input logic exp_rng, input string tag);
    fetch_valid[d] = 1'b1;
    fetch_pc[d]    = pc;
    tick();
    fetch_valid[d] = 1'b0;
    check({tag, "_valid"}, 32'(instr_valid[d]), 32'd1);
    check({tag, "_instr"}, instruction[d], exp_instr);
    check({tag, "_mis"}, 32'(fault_misalign[d]), 32'(exp_mis));
    check({tag, "_rng"}, 32'(fault_range[d]), 32'(exp_rng));
  endtask

  // Count cycles after reset release until fetch_ready rises (bounded).
  task automatic wait_ready(input int d, output int n);
    n = -1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (fetch_ready[d]) begin
        n = c;
        break;
      end
    end
  endtask

  logic [31:0] prog [3];
  logic [31:0] ovf  [6];
  int first_rdy [2];
  int n_acc;
  int n_wait;

  initial begin
    prog[0] = 32'h2009_0006; prog[1] = 32'h2008_0001; prog[2] = 32'h0108_4020;
    ovf[0] = 32'h1111_1111; ovf[1] = 32'h2222_2222; ovf[2] = 32'h3333_3333;
    ovf[3] = 32'h4444_4444; ovf[4] = 32'h5555_5555; ovf[5] = 32'h6666_6666;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      load_start[d] = 1'b0; load_valid[d] = 1'b0; load_data[d] = '0; load_last[d] = 1'b0;
      fetch_valid[d] = 1'b0; fetch_pc[d] = '0;
    end
    repeat (2) tick();

    // Reset values on both instances.
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_load_ready_%0d", d), 32'(load_ready[d]), 32'd0);
      check($sformatf("rst_load_done_%0d", d), 32'(load_done[d]), 32'd0);
      check($sformatf("rst_fetch_ready_%0d", d), 32'(fetch_ready[d]), 32'd0);
      check($sformatf("rst_instr_valid_%0d", d), 32'(instr_valid[d]), 32'd0);
      check($sformatf("rst_instruction_%0d", d), instruction[d], 32'd0);
      check($sformatf("rst_faults_%0d", d), 32'({fault_misalign[d], fault_range[d]}), 32'd0);
    end

    // Clear lasts DEPTH edges: ready is first seen after edge DEPTH-1, i.e. tick DEPTH.
    rst = 1'b0;
    first_rdy[0] = -1;
    first_rdy[1] = -1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      for (int d = 0; d < 2; d++)
        if (first_rdy[d] < 0 && fetch_ready[d]) first_rdy[d] = c;
    end
    check("clear_cycles_64", 32'(first_rdy[0]), 32'd64);
    check("clear_cycles_4", 32'(first_rdy[1]), 32'd4);

    fetch_chk(0, 32'h0, 32'h0, 1'b0, 1'b0, "boot_pc0");

    // Fetch accepted together with load_start: fetch completes, LOAD entered.
    fetch_valid[0] = 1'b1; fetch_pc[0] = 32'h4; load_start[0] = 1'b1;
    tick();
    fetch_valid[0] = 1'b0; load_start[0] = 1'b0;
    check("simul_instr_valid", 32'(instr_valid[0]), 32'd1);
    check("simul_instruction", instruction[0], 32'h0);
    check("simul_fetch_ready", 32'(fetch_ready[0]), 32'd0);
    check("simul_load_ready", 32'(load_ready[0]), 32'd1);

    // Three-word load, last on the third word.
    for (int i = 0; i < 3; i++) begin
      load_valid[0] = 1'b1; load_data[0] = prog[i]; load_last[0] = (i == 2);
      tick();
      check($sformatf("load3_done_%0d", i), 32'(load_done[0]), 32'(i == 2));
    end
    load_valid[0] = 1'b0; load_last[0] = 1'b0;
    check("load3_fetch_ready", 32'(fetch_ready[0]), 32'd1);
    check("load3_load_ready", 32'(load_ready[0]), 32'd0);
    tick();
    check("load3_done_drop", 32'(load_done[0]), 32'd0);

    // Back-to-back fetches of the loaded program.
    fetch_chk(0, 32'h0, prog[0], 1'b0, 1'b0, "prog_pc0");
    fetch_chk(0, 32'h4, prog[1], 1'b0, 1'b0, "prog_pc4");
    fetch_chk(0, 32'h8, prog[2], 1'b0, 1'b0, "prog_pc8");
    tick();
    check("idle_valid", 32'(instr_valid[0]), 32'd0);
    check("idle_hold", instruction[0], prog[2]);

    // Faults.
    fetch_chk(0, 32'h6,   32'h0, 1'b1, 1'b0, "fault_mis");
    fetch_chk(0, 32'h100, 32'h0, 1'b0, 1'b1, "fault_rng");
    fetch_chk(0, 32'h102, 32'h0, 1'b1, 1'b1, "fault_both");
    tick();
    check("fault_idle_flags", 32'({instr_valid[0], fault_misalign[0], fault_range[0]}), 32'd0);
    check("fault_idle_hold", instruction[0], 32'h0);

    // Overflow load on DEPTH=4: six words offered, no load_last.
    load_start[1] = 1'b1;
    tick();
    load_start[1] = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      load_valid[1] = 1'b1; load_data[1] = ovf[i];
      if (load_ready[1]) n_acc++;
      tick();
      if (i == 3) begin
        check("ovf_done", 32'(load_done[1]), 32'd1);
        check("ovf_ready_drop", 32'(load_ready[1]), 32'd0);
      end
    end
    load_valid[1] = 1'b0;
    check("ovf_accepted", 32'(n_acc), 32'd4);
    for (int i = 0; i < 4; i++)
      fetch_chk(1, 32'(i * 4), ovf[i], 1'b0, 1'b0, $sformatf("ovf_rd%0d", i));

    // Partial reload of one word.
    load_start[1] = 1'b1;
    tick();
    load_start[1] = 1'b0;
    load_valid[1] = 1'b1; load_data[1] = 32'hDEAD_BEEF; load_last[1] = 1'b1;
    tick();
    load_valid[1] = 1'b0; load_last[1] = 1'b0;
    check("partial_done", 32'(load_done[1]), 32'd1);
    fetch_chk(1, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, "partial_rd0");
    for (int i = 1; i < 4; i++)
      fetch_chk(1, 32'(i * 4), ovf[i], 1'b0, 1'b0, $sformatf("partial_rd%0d", i));

    // Reset in the middle of a load on DEPTH=64.
    fetch_chk(0, 32'h0, prog[0], 1'b0, 1'b0, "pre_rst_rd0");
    load_start[0] = 1'b1;
    tick();
    load_start[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid[0] = 1'b1; load_data[0] = 32'hA5A5_0000 + 32'(i);
      tick();
    end
    load_valid[0] = 1'b1; load_data[0] = 32'hA5A5_0002;
    rst = 1'b1;
    #1;
    check("midrst_load_ready", 32'(load_ready[0]), 32'd0);
    check("midrst_fetch_ready", 32'(fetch_ready[0]), 32'd0);
    check("midrst_instruction", instruction[0], 32'h0);
    check("midrst_instr_valid", 32'(instr_valid[0]), 32'd0);
    load_valid[0] = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    wait_ready(0, n_wait);
    check("midrst_clear_cycles", 32'(n_wait), 32'd64);
    for (int i = 0; i < 64; i++)
      fetch_chk(0, 32'(i * 4), 32'h0, 1'b0, 1'b0, $sformatf("post_clear_rd%0d", i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
